// File: rtl/heartaware_pkg.sv
// heartaware_pkg: shared SD block/FIFO sizes and the streamer FSM encoding (also the state_dbg code).
package heartaware_pkg;
  localparam int SD_BLOCK_BYTES   = 512;
  localparam int AUDIO_FIFO_DEPTH = 16384;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ROOM = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_XFER      = 3'd3,
    ST_NEXT      = 3'd4,
    ST_DRAIN     = 3'd5
  } state_e;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer plus registered rising-edge pulse (pulse 3 cycles after the edge).
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic pulse_o
);
  logic [2:0] sync_q;
  logic       pulse_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], d_i};
      pulse_q <= sync_q[1] & ~sync_q[2];
    end
  end
  assign pulse_o = pulse_q;
endmodule

// File: rtl/sd_audio_stream_ctrl.sv
// sd_audio_stream_ctrl: walks SD blocks into the sample FIFO and paces FIFO pops at the sample rate.
module sd_audio_stream_ctrl
  import heartaware_pkg::*;
#(
  parameter int BLOCK_BYTES = SD_BLOCK_BYTES,
  parameter int FIFO_DEPTH  = AUDIO_FIFO_DEPTH,
  parameter int CNT_W       = 14
) (
  input  logic             clk_100mhz,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [31:0]      start_addr,
  input  logic [31:0]      end_addr,
  input  logic             sample_clk,
  input  logic             sd_ready,
  input  logic             sd_byte_available,
  input  logic [CNT_W-1:0] fifo_count,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             sd_rd,
  output logic [31:0]      sd_adr,
  output logic             fifo_wr_en,
  output logic             fifo_rd_en,
  output logic             busy,
  output logic             playing,
  output logic             overflow,
  output logic [15:0]      underrun_count,
  output logic [2:0]       state_dbg
);
  localparam int               BC_W     = $clog2(BLOCK_BYTES + 1);
  localparam logic [BC_W-1:0]  BLK_CNT  = BC_W'(BLOCK_BYTES);
  localparam logic [CNT_W:0]   ROOM_MAX = (CNT_W+1)'(FIFO_DEPTH - BLOCK_BYTES);
  localparam logic [31:0]      ADR_STEP = 32'(BLOCK_BYTES);

  state_e            state_q, state_d;
  logic [31:0]       adr_q, adr_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [15:0]       under_q, under_d;
  logic              stop_pend_q, stop_pend_d;
  logic              playing_q, playing_d;
  logic              overflow_q, overflow_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              byte_edge, tick, room;

  sync_edge_detect u_byte_sync (
    .clk_i(clk_100mhz), .rst_ni(reset_n), .d_i(sd_byte_available), .pulse_o(byte_edge)
  );
  sync_edge_detect u_tick_sync (
    .clk_i(clk_100mhz), .rst_ni(reset_n), .d_i(sample_clk), .pulse_o(tick)
  );

  assign room = {1'b0, fifo_count} <= ROOM_MAX;

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      adr_q       <= '0;
      byte_cnt_q  <= '0;
      under_q     <= '0;
      stop_pend_q <= 1'b0;
      playing_q   <= 1'b0;
      overflow_q  <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      byte_cnt_q  <= byte_cnt_d;
      under_q     <= under_d;
      stop_pend_q <= stop_pend_d;
      playing_q   <= playing_d;
      overflow_q  <= overflow_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    byte_cnt_d  = byte_cnt_q;
    under_d     = under_q;
    stop_pend_d = stop_pend_q;
    playing_d   = playing_q;
    overflow_d  = overflow_q;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    if (playing_q && tick) begin
      if (!fifo_empty) rd_d = 1'b1;
      else if (under_q != 16'hFFFF) under_d = under_q + 16'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (stop) playing_d = 1'b0;
        else if (start) begin
          adr_d       = start_addr;
          byte_cnt_d  = '0;
          overflow_d  = 1'b0;
          under_d     = '0;
          stop_pend_d = 1'b0;
          state_d     = ST_WAIT_ROOM;
        end
      end
      ST_WAIT_ROOM: begin
        if (stop) begin
          playing_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (room && sd_ready) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (stop) stop_pend_d = 1'b1;
        if (!sd_ready) begin
          byte_cnt_d = '0;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        if (stop) stop_pend_d = 1'b1;
        if (byte_edge) begin
          // A byte that finds the FIFO full is dropped but still counts toward the block.
          if (fifo_full) overflow_d = 1'b1;
          else wr_d = 1'b1;
          if (byte_cnt_q != BLK_CNT) byte_cnt_d = byte_cnt_q + 1'b1;
        end else if (byte_cnt_q == BLK_CNT && sd_ready) begin
          if (stop || stop_pend_q) begin
            playing_d   = 1'b0;
            stop_pend_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            playing_d = 1'b1;
            state_d   = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        if (stop) begin
          playing_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (adr_q == end_addr && !loop_en) state_d = ST_DRAIN;
        else begin
          adr_d   = (adr_q == end_addr) ? start_addr : adr_q + ADR_STEP;
          state_d = ST_WAIT_ROOM;
        end
      end
      ST_DRAIN: begin
        if (stop || fifo_empty) begin
          playing_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sd_rd          = state_q == ST_ISSUE;
  assign sd_adr         = adr_q;
  assign fifo_wr_en     = wr_q;
  assign fifo_rd_en     = rd_q;
  assign busy           = state_q != ST_IDLE;
  assign playing        = playing_q;
  assign overflow       = overflow_q;
  assign underrun_count = under_q;
  assign state_dbg      = state_q;
endmodule

// File: tb/tb_sd_audio_stream_ctrl.sv
// tb_sd_audio_stream_ctrl: directed + randomized checks of the SD audio streamer against a simple SD/FIFO model.
module tb_sd_audio_stream_ctrl;
  import heartaware_pkg::*;
  logic        clk_100mhz = 1'b0;
  logic        reset_n, start, stop, loop_en, sample_clk, sd_ready, sd_byte_available;
  logic        fifo_full, fifo_empty;
  logic [31:0] start_addr, end_addr;
  logic [13:0] fifo_count;
  logic        sd_rd, fifo_wr_en, fifo_rd_en, busy, playing, overflow;
  logic [31:0] sd_adr;
  logic [15:0] underrun_count;
  logic [2:0]  state_dbg;
  int          total = 0, bad = 0;
  int          wr_cnt = 0, rd_cnt = 0;
  logic        sd_rd_prev = 1'b0;
  logic [31:0] adr_log[$];
  int          under_exp;

  sd_audio_stream_ctrl dut (
    .clk_100mhz(clk_100mhz), .reset_n(reset_n), .start(start), .stop(stop), .loop_en(loop_en),
    .start_addr(start_addr), .end_addr(end_addr), .sample_clk(sample_clk), .sd_ready(sd_ready),
    .sd_byte_available(sd_byte_available), .fifo_count(fifo_count), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .sd_rd(sd_rd), .sd_adr(sd_adr), .fifo_wr_en(fifo_wr_en),
    .fifo_rd_en(fifo_rd_en), .busy(busy), .playing(playing), .overflow(overflow),
    .underrun_count(underrun_count), .state_dbg(state_dbg)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  always @(negedge clk_100mhz) begin
    if (fifo_wr_en) wr_cnt++;
    if (fifo_rd_en) rd_cnt++;
    if (sd_rd && !sd_rd_prev) adr_log.push_back(sd_adr);
    sd_rd_prev = sd_rd;
  end

  // SD controller model: accepts a request, then streams 512 byte strobes; shares the reset.
  initial begin
    sd_ready = 1'b1;
    sd_byte_available = 1'b0;
    forever begin
      @(negedge clk_100mhz);
      if (reset_n && sd_rd && sd_ready) begin
        repeat ($urandom_range(1, 3)) @(negedge clk_100mhz);
        sd_ready = 1'b0;
        for (int b = 0; b < 512 && reset_n; b++) begin
          sd_byte_available = 1'b1;
          repeat ($urandom_range(2, 3)) @(negedge clk_100mhz);
          sd_byte_available = 1'b0;
          repeat ($urandom_range(2, 3)) @(negedge clk_100mhz);
        end
        sd_ready = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {7'b0, sd_rd, sd_adr, fifo_wr_en, fifo_rd_en, busy, playing, overflow, underrun_count, state_dbg};
  endfunction

  task automatic wait_for(input logic [2:0] st, input int maxc, input string tag);
    int n = 0;
    while (state_dbg !== st && n < maxc) begin
      @(negedge clk_100mhz);
      n++;
    end
    chk(tag, state_dbg, st);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk_100mhz);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk_100mhz);
    stop = 1'b0;
  endtask

  task automatic tick_n(input int k);
    for (int i = 0; i < k; i++) begin
      sample_clk = 1'b1;
      repeat (3) @(negedge clk_100mhz);
      sample_clk = 1'b0;
      repeat (3) @(negedge clk_100mhz);
    end
    repeat (3) @(negedge clk_100mhz);
  endtask

  task automatic run_walk(input logic [31:0] s, input int n);
    logic [31:0] exp_adr;
    start_addr = s;
    end_addr   = s + 32'(n - 1) * 32'd512;
    loop_en    = 1'b0;
    fifo_empty = 1'b0;
    wr_cnt     = 0;
    adr_log.delete();
    pulse_start();
    wait_for(ST_DRAIN, n * 4000, "walk_drain");
    chk("walk_nrd", adr_log.size(), n);
    for (int i = 0; i < n; i++) begin
      exp_adr = s + 32'(i) * 32'd512;
      chk("walk_adr", (i < adr_log.size()) ? adr_log[i] : 32'hDEAD_BEEF, exp_adr);
    end
    chk("walk_wr", wr_cnt, n * 512);
    fifo_empty = 1'b1;
    wait_for(ST_IDLE, 10, "walk_idle");
  endtask

  initial begin
    int n, k;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    start_addr = '0; end_addr = '0; sample_clk = 1'b0;
    fifo_count = '0; fifo_full = 1'b0; fifo_empty = 1'b1;
    repeat (3) @(negedge clk_100mhz);
    chk("reset_outs", outs(), 64'd0);
    reset_n = 1'b1;
    @(negedge clk_100mhz);
    start_addr = 32'h400; end_addr = 32'h400;
    start = 1'b1; stop = 1'b1;
    @(negedge clk_100mhz);
    start = 1'b0; stop = 1'b0;
    @(negedge clk_100mhz);
    chk("start_stop_idle", busy, 0);

    wr_cnt = 0; adr_log.delete(); fifo_empty = 1'b0;
    pulse_start();
    wait_for(ST_DRAIN, 4000, "single_drain");
    chk("single_wr", wr_cnt, 512);
    chk("single_nrd", adr_log.size(), 1);
    chk("single_adr", (adr_log.size() > 0) ? adr_log[0] : 32'hDEAD_BEEF, 32'h400);
    chk("single_playing", playing, 1);
    fifo_empty = 1'b1;
    wait_for(ST_IDLE, 10, "single_idle");
    chk("single_play_off", playing, 0);

    run_walk(32'h0, 4);
    run_walk(32'($urandom_range(0, 4000)) * 32'd512, 2);
    run_walk(32'hFFFF_FC00, 3);

    start_addr = 32'h0; end_addr = 32'h600; loop_en = 1'b1;
    wr_cnt = 0; adr_log.delete(); fifo_empty = 1'b0;
    pulse_start();
    n = 0;
    while (adr_log.size() < 6 && n < 20000) begin
      @(negedge clk_100mhz);
      n++;
    end
    chk("loop_busy", busy, 1);
    for (int i = 0; i < 6; i++)
      chk("loop_adr", (i < adr_log.size()) ? adr_log[i] : 32'hDEAD_BEEF, 32'((i % 4) * 512));
    pulse_stop();
    wait_for(ST_IDLE, 4000, "loop_stop_idle");
    chk("loop_wr", wr_cnt, 6 * 512);
    chk("loop_nrd", adr_log.size(), 6);
    loop_en = 1'b0;

    start_addr = 32'h0; end_addr = 32'h600;
    wr_cnt = 0; adr_log.delete();
    pulse_start();
    n = 0;
    while (wr_cnt < 100 && n < 4000) begin
      @(negedge clk_100mhz);
      n++;
    end
    pulse_stop();
    wait_for(ST_IDLE, 4000, "stop_idle");
    chk("stop_wr", wr_cnt, 512);
    repeat (50) @(negedge clk_100mhz);
    chk("stop_nrd", adr_log.size(), 1);
    chk("stop_busy", busy, 0);

    fifo_count = 14'd16000; start_addr = 32'h800; end_addr = 32'h800;
    wr_cnt = 0; adr_log.delete(); fifo_empty = 1'b0;
    pulse_start();
    repeat (20) @(negedge clk_100mhz);
    chk("bp_state", state_dbg, ST_WAIT_ROOM);
    chk("bp_no_rd", sd_rd, 0);
    fifo_count = 14'd15873;
    repeat (5) @(negedge clk_100mhz);
    chk("bp_edge_no_rd", adr_log.size(), 0);
    fifo_count = 14'd15872;
    repeat (2) @(negedge clk_100mhz);
    chk("bp_rd", adr_log.size(), 1);
    chk("bp_adr", (adr_log.size() > 0) ? adr_log[0] : 32'hDEAD_BEEF, 32'h800);
    fifo_count = '0;
    wait_for(ST_DRAIN, 4000, "bp_drain");
    chk("bp_wr", wr_cnt, 512);
    fifo_empty = 1'b1;
    wait_for(ST_IDLE, 10, "bp_idle");

    start_addr = 32'h0; end_addr = 32'h0; loop_en = 1'b1; fifo_empty = 1'b0;
    pulse_start();
    n = 0;
    while (playing !== 1'b1 && n < 4000) begin
      @(negedge clk_100mhz);
      n++;
    end
    chk("ur_playing", playing, 1);
    rd_cnt = 0; under_exp = 0;
    fifo_empty = 1'b1;
    tick_n(5);
    under_exp = (under_exp + 5 > 65535) ? 65535 : under_exp + 5;
    chk("ur_count", underrun_count, 64'(under_exp));
    chk("ur_no_rd", rd_cnt, 0);
    fifo_empty = 1'b0;
    k = $urandom_range(2, 5);
    tick_n(k);
    chk("rd_count", rd_cnt, k);
    chk("ur_hold", underrun_count, 64'(under_exp));
    force dut.under_q = 16'hFFFE;
    @(negedge clk_100mhz);
    release dut.under_q;
    under_exp = 16'hFFFE;
    fifo_empty = 1'b1;
    tick_n(3);
    under_exp = (under_exp + 3 > 65535) ? 65535 : under_exp + 3;
    chk("ur_sat", underrun_count, 64'(under_exp));
    fifo_empty = 1'b0; loop_en = 1'b0;
    pulse_stop();
    wait_for(ST_IDLE, 4000, "ur_stop_idle");
    chk("ur_kept_idle", underrun_count, 16'hFFFF);

    start_addr = 32'h400; end_addr = 32'h400; fifo_full = 1'b1; wr_cnt = 0;
    pulse_start();
    chk("ur_clear_on_start", underrun_count, 0);
    wait_for(ST_DRAIN, 4000, "ovf_drain");
    chk("ovf_flag", overflow, 1);
    chk("ovf_no_wr", wr_cnt, 0);
    fifo_full = 1'b0; fifo_empty = 1'b1;
    wait_for(ST_IDLE, 10, "ovf_idle");
    chk("ovf_sticky", overflow, 1);

    fifo_empty = 1'b0; wr_cnt = 0;
    pulse_start();
    chk("ovf_clear_on_start", overflow, 0);
    n = 0;
    while (wr_cnt < 50 && n < 4000) begin
      @(negedge clk_100mhz);
      n++;
    end
    #2 reset_n = 1'b0;
    #1 chk("reset_async", outs(), 64'd0);
    repeat (5) @(negedge clk_100mhz);
    reset_n = 1'b1;
    repeat (20) @(negedge clk_100mhz);
    chk("reset_idle", busy, 0);
    chk("reset_no_rd", sd_rd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
